// File: rtl/sounder_pkg.sv
// Shared types and defaults for the sounder TX burst envelope path.
package sounder_pkg;

    localparam int unsigned DEF_WIDTH     = 14;
    localparam int unsigned DEF_RAMP_LOG2 = 4;
    localparam int unsigned LEN_W         = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_ON,
        S_RAMP_DN,
        S_OFF
    } state_t;

endpackage

// File: rtl/sounder_ramp_scale.sv
// Signed sample times unsigned gain in [0, 2^RAMP_LOG2], arithmetic shift back to WIDTH bits.
module sounder_ramp_scale
    import sounder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned RAMP_LOG2 = DEF_RAMP_LOG2
) (
    input  logic [WIDTH-1:0]   x_i,
    input  logic [RAMP_LOG2:0] gain_i,
    output logic [WIDTH-1:0]   y_o
);

    localparam int unsigned PW = WIDTH + RAMP_LOG2 + 1;

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;

    // gain <= 2^R keeps the product inside PW bits, so the truncation is exact
    always_comb begin
        x_ext = {{(RAMP_LOG2 + 1){x_i[WIDTH-1]}}, x_i};
        g_ext = {{WIDTH{1'b0}}, gain_i};
        prod  = x_ext * g_ext;
        y_o   = WIDTH'(prod >>> RAMP_LOG2);
    end

endmodule

// File: rtl/sounder_tx_burst.sv
// Gates the PN chip stream into periodic bursts with start/active markers.
// Define SOUNDER_TX_RAMP_EN for linear edge ramps; otherwise bursts are hard-gated.
module sounder_tx_burst
    import sounder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned RAMP_LOG2 = DEF_RAMP_LOG2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ena_i,
    input  logic             strobe_i,
    input  logic [LEN_W-1:0] on_len_i,
    input  logic [LEN_W-1:0] off_len_i,
    input  logic [WIDTH-1:0] tx_i_i,
    input  logic [WIDTH-1:0] tx_q_i,
    output logic [WIDTH-1:0] tx_i_o,
    output logic [WIDTH-1:0] tx_q_o,
    output logic             burst_o,
    output logic             sob_o
);

    localparam int unsigned   GW        = RAMP_LOG2 + 1;
    localparam logic [GW-1:0] GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
`ifdef SOUNDER_TX_RAMP_EN
    localparam logic [LEN_W-1:0] RAMP_LAST = LEN_W'((1 << RAMP_LOG2) - 1);
`endif

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] on_len_q, on_len_d;
    logic [LEN_W-1:0] off_len_q, off_len_d;
    logic [GW-1:0]    gain;
    logic             load_d, sob_d, burst_d;
    logic             start_burst, enter_on, leave_burst;
    logic [WIDTH-1:0] shaped_i, shaped_q;

    // state_q is the state in which the most recent strobe was processed
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        on_len_d    = on_len_q;
        off_len_d   = off_len_q;
        gain        = '0;
        load_d      = 1'b0;
        sob_d       = 1'b0;
        start_burst = 1'b0;
        enter_on    = 1'b0;
        leave_burst = 1'b0;
        if (!ena_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (strobe_i) begin
            load_d = 1'b1;
            case (state_q)
                S_IDLE: start_burst = 1'b1;
`ifdef SOUNDER_TX_RAMP_EN
                S_RAMP_UP: begin
                    if (cnt_q == RAMP_LAST) begin
                        enter_on = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        gain  = GW'(cnt_d);
                    end
                end
                S_RAMP_DN: begin
                    if (cnt_q == RAMP_LAST) begin
                        leave_burst = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        gain  = GW'(RAMP_LAST - cnt_d);
                    end
                end
`endif
                S_ON: begin
                    if (on_len_q == '0 || cnt_q < on_len_q) begin
                        gain = GAIN_FULL;
                        if (on_len_q != '0) cnt_d = cnt_q + 1'b1;
                    end else begin
`ifdef SOUNDER_TX_RAMP_EN
                        state_d = S_RAMP_DN;
                        cnt_d   = '0;
                        gain    = GW'(RAMP_LAST);
`else
                        leave_burst = 1'b1;
`endif
                    end
                end
                S_OFF: begin
                    if (cnt_q < off_len_q) cnt_d = cnt_q + 1'b1;
                    else                   start_burst = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // a zero gap chains straight into the next burst on this same strobe
            if (leave_burst) begin
                if (off_len_i == '0) begin
                    start_burst = 1'b1;
                end else begin
                    state_d   = S_OFF;
                    cnt_d     = LEN_W'(1);
                    off_len_d = off_len_i;
                end
            end
            if (start_burst) begin
                sob_d = 1'b1;
`ifdef SOUNDER_TX_RAMP_EN
                state_d = S_RAMP_UP;
                cnt_d   = '0;
                gain    = '0;
`else
                enter_on = 1'b1;
`endif
            end
            if (enter_on) begin
                state_d  = S_ON;
                cnt_d    = LEN_W'(1);
                on_len_d = on_len_i;
                gain     = GAIN_FULL;
            end
        end
        burst_d = (state_d == S_RAMP_UP) || (state_d == S_ON) || (state_d == S_RAMP_DN);
    end

`ifdef SOUNDER_TX_RAMP_EN
    sounder_ramp_scale #(.WIDTH(WIDTH), .RAMP_LOG2(RAMP_LOG2)) u_scale_i (
        .x_i    (tx_i_i),
        .gain_i (gain),
        .y_o    (shaped_i)
    );
    sounder_ramp_scale #(.WIDTH(WIDTH), .RAMP_LOG2(RAMP_LOG2)) u_scale_q (
        .x_i    (tx_q_i),
        .gain_i (gain),
        .y_o    (shaped_q)
    );
`else
    always_comb begin
        shaped_i = (gain == GAIN_FULL) ? tx_i_i : '0;
        shaped_q = (gain == GAIN_FULL) ? tx_q_i : '0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            tx_i_o    <= '0;
            tx_q_o    <= '0;
            burst_o   <= 1'b0;
            sob_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            sob_o     <= sob_d;
            if (!ena_i) begin
                tx_i_o  <= '0;
                tx_q_o  <= '0;
                burst_o <= 1'b0;
            end else if (load_d) begin
                tx_i_o  <= shaped_i;
                tx_q_o  <= shaped_q;
                burst_o <= burst_d;
            end
        end
    end

endmodule

// File: tb/tb_sounder_tx_burst.sv
// Scoreboard bench for sounder_tx_burst; the reference model works from burst position arithmetic.
module tb_sounder_tx_burst;
    import sounder_pkg::*;

    localparam int W    = DEF_WIDTH;
    localparam int R    = DEF_RAMP_LOG2;
    localparam int FULL = 1 << R;
`ifdef SOUNDER_TX_RAMP_EN
    localparam int N = 1 << R;
`else
    localparam int N = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ena = 1'b0;
    logic                strobe = 1'b0;
    logic [15:0]         on_len = '0;
    logic [15:0]         off_len = '0;
    logic [W-1:0]        tx_i = '0;
    logic [W-1:0]        tx_q = '0;
    logic signed [W-1:0] y_i, y_q;
    logic                burst, sob;

    sounder_tx_burst #(.WIDTH(W), .RAMP_LOG2(R)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .ena_i     (ena),
        .strobe_i  (strobe),
        .on_len_i  (on_len),
        .off_len_i (off_len),
        .tx_i_i    (tx_i),
        .tx_q_i    (tx_q),
        .tx_i_o    (y_i),
        .tx_q_o    (y_q),
        .burst_o   (burst),
        .sob_o     (sob)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        int burst;
        int sob;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cur_on = 8;
    int   cur_off = 4;

    // model: position within the current burst plus the lengths it latched
    int m_p = 0;
    int m_lon = 0;
    int m_loff = 0;
    bit m_active = 1'b0;
    bit m_lon_valid = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_strobe(input int xv_i, input int xv_q);
        exp_t e;
        int   g;
        if (!m_active) begin
            m_active = 1'b1;
            m_p      = 0;
        end else begin
            m_p++;
            if (m_lon_valid && m_lon != 0) begin
                if (m_p == 2 * N + m_lon) begin
                    m_loff = int'(off_len);
                    if (m_loff == 0) m_p = 0;
                end else if (m_p == 2 * N + m_lon + m_loff) begin
                    m_p = 0;
                end
            end
        end
        if (m_p == 0) m_lon_valid = 1'b0;
        if (m_p == N) begin
            m_lon       = int'(on_len);
            m_lon_valid = 1'b1;
        end
        if (m_p < N)                           g = m_p;
        else if (m_lon == 0 || m_p < N + m_lon) g = FULL;
        else if (m_p < 2 * N + m_lon)           g = 2 * N + m_lon - 1 - m_p;
        else                                    g = 0;
        e.i     = (xv_i * g) >>> R;
        e.q     = (xv_q * g) >>> R;
        e.burst = ((m_p < N) || m_lon == 0 || m_p < 2 * N + m_lon) ? 1 : 0;
        e.sob   = (m_p == 0) ? 1 : 0;
        sbq.push_back(e);
    endtask

    task automatic drive(input bit stb, input bit en, input int xv_i, input int xv_q);
        @(negedge clk);
        strobe  = stb;
        ena     = en;
        on_len  = 16'(cur_on);
        off_len = 16'(cur_off);
        tx_i    = xv_i[W-1:0];
        tx_q    = xv_q[W-1:0];
        if (!en)                  m_active = 1'b0;
        else if (stb && rst_n)    model_strobe(xv_i, xv_q);
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
    endfunction

    // monitor: one expected entry per accepted strobe, hold checks otherwise
    initial begin
        exp_t e;
        exp_t last;
        bit   s_rst, s_ena, s_stb;
        last = '{0, 0, 0, 0};
        forever begin
            @(posedge clk);
            s_rst = rst_n;
            s_ena = ena;
            s_stb = strobe;
            #1;
            if (!s_rst) begin
                last = '{0, 0, 0, 0};
            end else if (!s_ena) begin
                chk("ena_lo_tx_i", int'(y_i), 0);
                chk("ena_lo_tx_q", int'(y_q), 0);
                chk("ena_lo_burst", int'(burst), 0);
                chk("ena_lo_sob", int'(sob), 0);
                last = '{0, 0, 0, 0};
            end else if (s_stb) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: actual=output expected=no_output at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("tx_i", int'(y_i), e.i);
                    chk("tx_q", int'(y_q), e.q);
                    chk("burst", int'(burst), e.burst);
                    chk("sob", int'(sob), e.sob);
                    last     = e;
                    last.sob = 0;
                end
            end else begin
                chk("hold_tx_i", int'(y_i), last.i);
                chk("hold_tx_q", int'(y_q), last.q);
                chk("hold_burst", int'(burst), last.burst);
                chk("hold_sob", int'(sob), 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_i", int'(y_i), 0);
        chk("rst_tx_q", int'(y_q), 0);
        chk("rst_burst", int'(burst), 0);
        chk("rst_sob", int'(sob), 0);
        rst_n = 1'b1;

        // constant full-scale input, strobe every 4 clocks, two full periods
        cur_on  = 8;
        cur_off = 4;
        for (int s = 0; s < 2 * (2 * N + 12); s++) begin
            drive(1'b1, 1'b1, 8191, -8191);
            repeat (3) drive(1'b0, 1'b1, 8191, -8191);
        end

        // async reset in the middle of ON
        for (int s = 0; s < N + 4; s++) drive(1'b1, 1'b1, 8191, -8191);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_i", int'(y_i), 0);
        chk("arst_tx_q", int'(y_q), 0);
        chk("arst_burst", int'(burst), 0);
        chk("arst_sob", int'(sob), 0);
        m_active = 1'b0;
        repeat (2) drive(1'b0, 1'b1, 8191, -8191);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 20; s++) drive(1'b1, 1'b1, 8191, -8191);

        // enable dropped together with the 5th strobe of a burst
        repeat (2) drive(1'b0, 1'b0, 0, 0);
        for (int s = 0; s < 4; s++) drive(1'b1, 1'b1, rand_sample(), rand_sample());
        drive(1'b1, 1'b0, 4000, -4000);
        drive(1'b0, 1'b0, 0, 0);
        for (int s = 0; s < 30; s++) drive(1'b1, 1'b1, rand_sample(), rand_sample());

        // continuous ON
        drive(1'b0, 1'b0, 0, 0);
        cur_on = 0;
        for (int s = 0; s < 1000; s++) drive(1'b1, 1'b1, rand_sample(), rand_sample());
        drive(1'b0, 1'b0, 0, 0);

        // back-to-back bursts
        cur_on  = 3;
        cur_off = 0;
        for (int s = 0; s < 120; s++) drive($urandom_range(0, 2) != 0, 1'b1, rand_sample(), rand_sample());

        // random lengths, strobe density and enable drops
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                cur_on  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
                cur_off = int'($urandom_range(0, 6));
            end
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 299) != 0, rand_sample(), rand_sample());
        end

        repeat (3) drive(1'b0, 1'b1, 0, 0);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
